// File: rtl/text_line_reader_pkg.sv
// text_line_reader_pkg: shared text RAM types, console geometry and reader FSM states.
package text_line_reader_pkg;
    localparam int CONSOLE_COLUMNS = 80;
    localparam int CONSOLE_ROWS = 50;
    localparam int TEXT_RAM_CHAR_WIDTH = 32;
    localparam int COL_IDX_W = $clog2(CONSOLE_COLUMNS);
    typedef logic [TEXT_RAM_CHAR_WIDTH-1:0] char_t;
    typedef char_t [CONSOLE_COLUMNS-1:0] line_t;
    localparam char_t BLANK_CHAR = 32'h0007fc20;
    typedef struct packed {
        logic       wren;
        logic [7:0] address;
        line_t      data;
    } TextRamRequest_t;
    typedef struct packed {
        line_t data;
    } TextRamResult_t;
    typedef enum logic [2:0] {IDLE = 3'd0, READ0 = 3'd1, READ1 = 3'd2, CAPTURE = 3'd3} state_t;
    function automatic line_t blank_line(char_t c);
        return {CONSOLE_COLUMNS{c}};
    endfunction
endpackage

// File: rtl/text_line_reader_if.sv
// text_line_reader_if: text RAM request/result bus between the line reader and the RAM.
interface text_line_reader_if;
    import text_line_reader_pkg::*;
    TextRamRequest_t ramReq;
    TextRamResult_t  ramRes;
    modport master(output ramReq, input ramRes);
    modport slave(input ramReq, output ramRes);
endinterface

// File: rtl/text_line_reader_line_pingpong_buffer.sv
// line_pingpong_buffer: two line buffers with a front select; whole-line writes, single-char reads.
module line_pingpong_buffer
    import text_line_reader_pkg::*;
#(
    parameter char_t BLANK = text_line_reader_pkg::BLANK_CHAR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic                 wr_sel_i,
    input  line_t                wr_line_i,
    input  logic [7:0]           wr_row_i,
    input  logic                 swap_i,
    input  logic [COL_IDX_W-1:0] rd_idx_i,
    output char_t                rd_char_o,
    output logic [7:0]           front_row_o,
    output logic                 front_o
);
    line_t      buf_q [2];
    logic [7:0] tag_q [2];
    logic       front_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q[0] <= blank_line(BLANK);
            buf_q[1] <= blank_line(BLANK);
            tag_q[0] <= 8'hff;
            tag_q[1] <= 8'hff;
            front_q  <= 1'b0;
        end else begin
            if (wr_en_i) begin
                buf_q[wr_sel_i] <= wr_line_i;
                tag_q[wr_sel_i] <= wr_row_i;
            end
            if (swap_i) front_q <= ~front_q;
        end
    end
    assign rd_char_o   = buf_q[front_q][rd_idx_i];
    assign front_row_o = tag_q[front_q];
    assign front_o     = front_q;
endmodule

// File: rtl/text_line_reader.sv
// text_line_reader: fetches one text row from RAM into the back line buffer and serves
// registered character reads (with cursor flag) from the front buffer.
module text_line_reader #(
    parameter int CONSOLE_COLUMNS = text_line_reader_pkg::CONSOLE_COLUMNS,
    parameter int CONSOLE_ROWS = text_line_reader_pkg::CONSOLE_ROWS,
    parameter text_line_reader_pkg::char_t BLANK_CHAR = text_line_reader_pkg::BLANK_CHAR
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fetch_req,
    input  logic [7:0]                  fetch_row,
    output logic                        fetch_busy,
    output logic                        fetch_done,
    input  logic                        swap,
    input  logic                        rd_en,
    input  logic [7:0]                  rd_col,
    output text_line_reader_pkg::char_t rd_char,
    output logic                        rd_valid,
    output logic                        rd_is_cursor,
    input  logic                        cursor_en,
    input  logic [7:0]                  cursor_row,
    input  logic [7:0]                  cursor_col,
    text_line_reader_if.master          ram,
    output logic [2:0]                  debug
);
    import text_line_reader_pkg::*;
    localparam logic [7:0] COLS8 = 8'(CONSOLE_COLUMNS);
    localparam logic [7:0] ROWS8 = 8'(CONSOLE_ROWS);
    state_t     state_q, state_d;
    logic [7:0] row_q, row_d, addr_q, addr_d;
    logic       target_q, target_d, blank_q, blank_d, pend_q, pend_d;
    logic       swap_now, front;
    logic [7:0] front_row;
    char_t      buf_char, rd_char_q;
    logic       rd_valid_q, rd_cur_q;
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        addr_d   = addr_q;
        target_d = target_q;
        blank_d  = blank_q;
        pend_d   = pend_q;
        swap_now = 1'b0;
        case (state_q)
            IDLE: begin
                swap_now = swap;
                if (fetch_req) begin
                    row_d    = fetch_row;
                    target_d = ~front;
                    blank_d  = fetch_row >= ROWS8;
                    addr_d   = blank_d ? addr_q : fetch_row;
                    state_d  = blank_d ? CAPTURE : READ0;
                end
            end
            READ0: begin
                pend_d  = pend_q | swap;
                state_d = READ1;
            end
            READ1: begin
                pend_d  = pend_q | swap;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // a pending swap lands on the same edge that commits the line
                swap_now = pend_q | swap;
                pend_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            addr_q     <= '0;
            target_q   <= 1'b0;
            blank_q    <= 1'b0;
            pend_q     <= 1'b0;
            rd_char_q  <= BLANK_CHAR;
            rd_valid_q <= 1'b0;
            rd_cur_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            target_q   <= target_d;
            blank_q    <= blank_d;
            pend_q     <= pend_d;
            rd_valid_q <= rd_en;
            rd_cur_q   <= rd_en & cursor_en & (front_row == cursor_row) & (rd_col == cursor_col);
            if (rd_en) rd_char_q <= rd_col < COLS8 ? buf_char : BLANK_CHAR;
        end
    end
    line_pingpong_buffer #(.BLANK(BLANK_CHAR)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (state_q == CAPTURE),
        .wr_sel_i   (target_q),
        .wr_line_i  (blank_q ? blank_line(BLANK_CHAR) : ram.ramRes.data),
        .wr_row_i   (row_q),
        .swap_i     (swap_now),
        .rd_idx_i   (rd_col < COLS8 ? rd_col[COL_IDX_W-1:0] : '0),
        .rd_char_o  (buf_char),
        .front_row_o(front_row),
        .front_o    (front)
    );
    assign ram.ramReq   = '{wren: 1'b0, address: addr_q, data: '0};
    assign fetch_busy   = state_q != IDLE;
    assign fetch_done   = state_q == CAPTURE;
    assign rd_char      = rd_char_q;
    assign rd_valid     = rd_valid_q;
    assign rd_is_cursor = rd_cur_q;
    assign debug        = state_q;
endmodule
